// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the control sequencer: states, opcodes, ALU selects and IR field positions.
// Pure declarations; no logic, no latency, no flow control.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5,
    ST_T5   = 3'd6,
    ST_HALT = 3'd7
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0110;
  localparam logic [3:0] ALU_OR  = 4'b0111;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  function automatic logic is_alu_op(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_known_op(input logic [4:0] op);
    return is_alu_op(op) || (op == OP_NOP) || (op == OP_HALT);
  endfunction

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    logic [3:0] code;
    code = ALU_ADD;
    case (op)
      OP_SUB:  code = ALU_SUB;
      OP_AND:  code = ALU_AND;
      OP_OR:   code = ALU_OR;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// 4-bit register field to 16-bit one-hot enable, all-zero when en is low.
// Purely combinational; no flow control.
module reg_sel_decoder (
  input  logic        en,
  input  logic [3:0]  sel,
  output logic [15:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer driving datapath strobes; Moore outputs, fetch waits in T1 on mem_rdy.
// Three-cycle execute for ALU ops; nop/halt/undefined opcodes finish in T2.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_rdy,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        PCin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        ZLowout,
  output logic [15:0] R_in,
  output logic [15:0] R_out,
  output logic [3:0]  ALUselect,
  output logic        run,
  output logic        illegal,
  output logic [15:0] retired
);

  state_t      state, state_nxt;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        rin_en, rout_en;
  logic [3:0]  rout_sel;
  logic        retire, illegal_set;
  logic        unused_ir_bits;

  assign opcode = IR[OPC_MSB:OPC_LSB];
  assign ra     = IR[RA_MSB:RA_LSB];
  assign rb     = IR[RB_MSB:RB_LSB];
  assign rc     = IR[RC_MSB:RC_LSB];
  assign unused_ir_bits = ^IR[RC_LSB-1:0];

  assign run = (state != ST_IDLE) && (state != ST_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (retire)      retired <= retired + 16'd1;
      if (illegal_set) illegal <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    PCout       = 1'b0;
    MARin       = 1'b0;
    IncPC       = 1'b0;
    PCin        = 1'b0;
    Read        = 1'b0;
    MDRin       = 1'b0;
    MDRout      = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    Zin         = 1'b0;
    ZLowout     = 1'b0;
    ALUselect   = ALU_ADD;
    rin_en      = 1'b0;
    rout_en     = 1'b0;
    rout_sel    = '0;
    retire      = 1'b0;
    illegal_set = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_T0;
      ST_T0: begin
        PCout     = 1'b1;
        MARin     = 1'b1;
        IncPC     = 1'b1;
        Zin       = 1'b1;
        state_nxt = ST_T1;
      end
      // Reloading PC from an unchanged Z while waiting is harmless.
      ST_T1: begin
        ZLowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = mem_rdy;
        if (mem_rdy) state_nxt = ST_T2;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        if (is_alu_op(opcode)) begin
          state_nxt = ST_T3;
        end else if (opcode == OP_HALT) begin
          state_nxt = ST_HALT;
          retire    = 1'b1;
        end else begin
          state_nxt   = ST_T0;
          retire      = (opcode == OP_NOP);
          illegal_set = !is_known_op(opcode);
        end
      end
      ST_T3: begin
        Yin       = 1'b1;
        rout_en   = 1'b1;
        rout_sel  = rb;
        state_nxt = ST_T4;
      end
      ST_T4: begin
        Zin       = 1'b1;
        rout_en   = 1'b1;
        rout_sel  = rc;
        ALUselect = alu_code(opcode);
        state_nxt = ST_T5;
      end
      ST_T5: begin
        ZLowout   = 1'b1;
        rin_en    = 1'b1;
        retire    = 1'b1;
        state_nxt = ST_T0;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  reg_sel_decoder u_rin_dec (
    .en     (rin_en),
    .sel    (ra),
    .onehot (R_in)
  );

  reg_sel_decoder u_rout_dec (
    .en     (rout_en),
    .sel    (rout_sel),
    .onehot (R_out)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction expected cycle traces built from the instruction rules,
// directed scenarios followed by a randomized instruction stream.
module tb_control_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mem_rdy;
  logic [31:0] IR;
  logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin, ZLowout;
  logic [15:0] R_in, R_out;
  logic [3:0]  ALUselect;
  logic        run, illegal;
  logic [15:0] retired;

  control_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mem_rdy   (mem_rdy),
    .IR        (IR),
    .PCout     (PCout),
    .MARin     (MARin),
    .IncPC     (IncPC),
    .PCin      (PCin),
    .Read      (Read),
    .MDRin     (MDRin),
    .MDRout    (MDRout),
    .IRin      (IRin),
    .Yin       (Yin),
    .Zin       (Zin),
    .ZLowout   (ZLowout),
    .R_in      (R_in),
    .R_out     (R_out),
    .ALUselect (ALUselect),
    .run       (run),
    .illegal   (illegal),
    .retired   (retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [10:0] s;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [3:0]  alu;
    logic        run;
  } obs_t;

  localparam logic [10:0] S_PCOUT   = 11'h400;
  localparam logic [10:0] S_MARIN   = 11'h200;
  localparam logic [10:0] S_INCPC   = 11'h100;
  localparam logic [10:0] S_PCIN    = 11'h080;
  localparam logic [10:0] S_READ    = 11'h040;
  localparam logic [10:0] S_MDRIN   = 11'h020;
  localparam logic [10:0] S_MDROUT  = 11'h010;
  localparam logic [10:0] S_IRIN    = 11'h008;
  localparam logic [10:0] S_YIN     = 11'h004;
  localparam logic [10:0] S_ZIN     = 11'h002;
  localparam logic [10:0] S_ZLOWOUT = 11'h001;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] exp_retired;
  logic        exp_illegal;

  function automatic obs_t mk(input logic [10:0] s, input logic [15:0] rin,
                              input logic [15:0] rout, input logic [3:0] alu, input logic r);
    obs_t o;
    o.s = s; o.rin = rin; o.rout = rout; o.alu = alu; o.run = r;
    return o;
  endfunction

  function automatic obs_t observe();
    return mk({PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin, ZLowout},
              R_in, R_out, ALUselect, run);
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Opcode classification straight from the instruction table.
  function automatic bit op_is_alu(input logic [4:0] op);
    return op inside {5'b00011, 5'b00100, 5'b01001, 5'b01010};
  endfunction

  function automatic bit op_is_defined(input logic [4:0] op);
    return op_is_alu(op) || op == 5'b11010 || op == 5'b11011;
  endfunction

  function automatic logic [3:0] op_alu(input logic [4:0] op);
    case (op)
      5'b00100: return 4'b0001;
      5'b01001: return 4'b0110;
      5'b01010: return 4'b0111;
      default:  return 4'b0000;
    endcase
  endfunction

  task automatic tick(input obs_t e, input logic mr, input logic st, input string tag);
    mem_rdy = mr;
    start   = st;
    #1;
    check(tag, 64'(observe()), 64'(e));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // One instruction from T0 onward, with 'waits' stalled cycles in T1.
  task automatic exec_instr(input logic [31:0] ir, input int waits, input string tag);
    logic [4:0]  op;
    logic [15:0] one, rin_m, rb_m, rc_m;
    op    = ir[31:27];
    one   = 16'h0001;
    rin_m = one << ir[26:23];
    rb_m  = one << ir[22:19];
    rc_m  = one << ir[18:15];
    IR    = ir;
    tick(mk(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 16'h0, 16'h0, 4'h0, 1'b1),
         1'($urandom), 1'($urandom), {tag, ".T0"});
    for (int i = 0; i < waits; i++)
      tick(mk(S_ZLOWOUT | S_PCIN | S_READ, 16'h0, 16'h0, 4'h0, 1'b1),
           1'b0, 1'($urandom), {tag, ".T1wait"});
    tick(mk(S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN, 16'h0, 16'h0, 4'h0, 1'b1),
         1'b1, 1'($urandom), {tag, ".T1"});
    tick(mk(S_MDROUT | S_IRIN, 16'h0, 16'h0, 4'h0, 1'b1),
         1'($urandom), 1'($urandom), {tag, ".T2"});
    if (op_is_alu(op)) begin
      tick(mk(S_YIN, 16'h0, rb_m, 4'h0, 1'b1), 1'($urandom), 1'($urandom), {tag, ".T3"});
      tick(mk(S_ZIN, 16'h0, rc_m, op_alu(op), 1'b1), 1'($urandom), 1'($urandom), {tag, ".T4"});
      tick(mk(S_ZLOWOUT, rin_m, 16'h0, 4'h0, 1'b1), 1'($urandom), 1'($urandom), {tag, ".T5"});
    end
    if (op_is_defined(op)) exp_retired = exp_retired + 16'd1;
    else                   exp_illegal = 1'b1;
    check({tag, ".retired"}, 64'(retired), 64'(exp_retired));
    check({tag, ".illegal"}, 64'(illegal), 64'(exp_illegal));
  endtask

  task automatic idle_to_start(input string tag);
    tick(mk(11'h0, 16'h0, 16'h0, 4'h0, 1'b0), 1'($urandom), 1'b0, {tag, ".idle"});
    tick(mk(11'h0, 16'h0, 16'h0, 4'h0, 1'b0), 1'($urandom), 1'b1, {tag, ".idle_start"});
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] ir;
    int          k;
    rst_n = 1'b0; start = 1'b0; mem_rdy = 1'b0; IR = 32'h0;
    exp_retired = 16'h0; exp_illegal = 1'b0;
    #1;
    check("reset.outputs", 64'(observe()), 64'(mk(11'h0, 16'h0, 16'h0, 4'h0, 1'b0)));
    check("reset.retired", 64'(retired), 64'h0);
    check("reset.illegal", 64'(illegal), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    idle_to_start("boot");
    exec_instr(32'h4A920000, 0, "and_r5_r2_r4");
    exec_instr({5'b00011, 4'd1, 4'd3, 4'd15, 15'h0}, 3, "add_wait3");
    exec_instr({5'b11010, 27'($urandom)}, 1, "nop");
    exec_instr({5'b11111, 27'($urandom)}, 0, "undef");

    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 9);
      if (k <= 5) begin
        case ($urandom_range(0, 3))
          0:       op = 5'b00011;
          1:       op = 5'b00100;
          2:       op = 5'b01001;
          default: op = 5'b01010;
        endcase
      end else if (k <= 7) begin
        op = 5'b11010;
      end else begin
        op = 5'(($urandom_range(0, 31)));
        while (op_is_defined(op)) op = 5'(($urandom_range(0, 31)));
      end
      ir = {op, 27'($urandom)};
      exec_instr(ir, $urandom_range(0, 3), "rand");
    end

    // Reset asserted partway through T4 of an add.
    IR = {5'b00011, 4'd7, 4'd1, 4'd9, 15'h0};
    tick(mk(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 16'h0, 16'h0, 4'h0, 1'b1), 1'b0, 1'b0, "rst4.T0");
    tick(mk(S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN, 16'h0, 16'h0, 4'h0, 1'b1), 1'b1, 1'b0, "rst4.T1");
    tick(mk(S_MDROUT | S_IRIN, 16'h0, 16'h0, 4'h0, 1'b1), 1'b0, 1'b0, "rst4.T2");
    tick(mk(S_YIN, 16'h0, 16'h0002, 4'h0, 1'b1), 1'b0, 1'b0, "rst4.T3");
    mem_rdy = 1'b1;
    #1;
    check("rst4.T4", 64'(observe()), 64'(mk(S_ZIN, 16'h0, 16'h0200, 4'h0, 1'b1)));
    #2 rst_n = 1'b0;
    #1;
    check("rst4.outputs", 64'(observe()), 64'(mk(11'h0, 16'h0, 16'h0, 4'h0, 1'b0)));
    check("rst4.retired", 64'(retired), 64'h0);
    check("rst4.illegal", 64'(illegal), 64'h0);
    exp_retired = 16'h0; exp_illegal = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    tick(mk(11'h0, 16'h0, 16'h0, 4'h0, 1'b0), 1'b1, 1'b0, "rst4.stay_idle");
    idle_to_start("resume");
    exec_instr({5'b00100, 4'd14, 4'd0, 4'd8, 15'h7FFF}, 2, "sub_after_reset");

    exec_instr({5'b11011, 27'($urandom)}, 1, "halt");
    tick(mk(11'h0, 16'h0, 16'h0, 4'h0, 1'b0), 1'b1, 1'b1, "halt.start_pulse");
    for (int i = 0; i < 4; i++)
      tick(mk(11'h0, 16'h0, 16'h0, 4'h0, 1'b0), 1'($urandom), 1'b0, "halt.hold");
    check("halt.retired", 64'(retired), 64'(exp_retired));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
